// File: rtl/fmc_fifo_pkg.sv
// Shared definitions for the FMC write FIFO: capture FSM states, status layout
// and drop counter saturation value.
package fmc_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } cap_state_t;

  localparam int unsigned ST_LEVEL_LSB = 0;
  localparam int unsigned ST_DROP_LSB  = 16;
  localparam int unsigned ST_OVF_BIT   = 31;

  localparam logic [7:0] DROP_CNT_MAX = 8'd255;

endpackage

// File: rtl/fmc_fifo_ram.sv
// Simple dual-port RAM, 32 bit wide, 2**DEPTH_LOG2 deep, registered read port.
module fmc_fifo_ram #(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fmc_wr_fifo.sv
// Captures FMC writes to STREAM_ADDR into a sync FIFO and streams them out (FWFT).
// Optional FMC_WR_FIFO_PEAK_EN adds a peak[15:0] high-water-mark output.
module fmc_wr_fifo
  import fmc_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter logic [15:0] STREAM_ADDR = 16'h0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] fmc_addr,
  input  logic [31:0] fmc_data_in,
  input  logic        fmc_ne,
  input  logic        fmc_nwe,
  input  logic        flush,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [31:0] status
`ifdef FMC_WR_FIFO_PEAK_EN
  ,
  output logic [15:0] peak
`endif
);

  localparam int unsigned AW = DEPTH_LOG2;
  localparam int unsigned PW = DEPTH_LOG2 + 1;

  logic        ne_s1, ne_s2, nwe_s1, nwe_s2;
  logic [15:0] addr_q, addr_q2;
  logic [31:0] data_q, data_q2;

  // Addr/data get a second stage so they line up with the 2-FF strobe sync;
  // the capture then never takes a sample from after the nwe rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ne_s1   <= 1'b1;
      ne_s2   <= 1'b1;
      nwe_s1  <= 1'b0;
      nwe_s2  <= 1'b0;
      addr_q  <= '0;
      addr_q2 <= '0;
      data_q  <= '0;
      data_q2 <= '0;
    end else begin
      ne_s1   <= fmc_ne;
      ne_s2   <= ne_s1;
      nwe_s1  <= fmc_nwe;
      nwe_s2  <= nwe_s1;
      addr_q  <= fmc_addr;
      addr_q2 <= addr_q;
      data_q  <= fmc_data_in;
      data_q2 <= data_q;
    end
  end

  cap_state_t  state;
  logic [31:0] cap_data;
  logic        nwe_high_seen;
  logic        push;

  // nwe_high_seen blocks re-arming on a write already in flight at reset/flush.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state         <= IDLE;
      cap_data      <= '0;
      nwe_high_seen <= 1'b0;
    end else begin
      if (nwe_s2) nwe_high_seen <= 1'b1;
      case (state)
        IDLE: begin
          if (nwe_high_seen && !ne_s2 && !nwe_s2 && addr_q2 == STREAM_ADDR) begin
            state         <= ARMED;
            cap_data      <= data_q2;
            nwe_high_seen <= 1'b0;
          end
        end
        ARMED: begin
          if (nwe_s2)     state <= COMMIT;
          else if (ne_s2) state <= IDLE;
          else            cap_data <= data_q2;
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign push = (state == COMMIT);

  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt, level, level_nxt;
  logic [AW-1:0] raddr;
  logic [31:0]   ram_rdata, ram_head, fwd_data;
  logic          fwd_valid, full, pop, wr_en, drop, overflow;
  logic [7:0]    drop_cnt;

  always_comb begin
    pop       = m_tvalid & m_tready;
    level     = wr_ptr - rd_ptr;
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    wr_en     = push & (!full | pop) & !flush;
    drop      = push & full & !pop & !flush;
    rd_nxt    = flush ? '0 : rd_ptr + PW'(pop);
    level_nxt = level + PW'(wr_en) - PW'(pop);
    raddr     = rd_nxt[AW-1:0] + AW'(1);
    ram_head  = fwd_valid ? fwd_data : ram_rdata;
  end

  fmc_fifo_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (cap_data),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  // RAM is read one entry ahead of the head; a write landing on that entry in
  // the same cycle is forwarded because the registered read returns stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      fwd_valid <= 1'b0;
      fwd_data  <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      m_tvalid  <= 1'b0;
      fwd_valid <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr    <= rd_nxt;
      m_tvalid  <= (level_nxt != '0);
      fwd_valid <= wr_en && (wr_ptr[AW-1:0] == raddr);
      fwd_data  <= cap_data;
      if (!m_tvalid) begin
        if (wr_en) m_tdata <= cap_data;
      end else if (pop) begin
        if (level > PW'(1)) m_tdata <= ram_head;
        else if (wr_en)     m_tdata <= cap_data;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != DROP_CNT_MAX) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    status                         = '0;
    status[ST_OVF_BIT]             = overflow;
    status[ST_DROP_LSB +: 8]       = drop_cnt;
    status[ST_LEVEL_LSB +: 16]     = 16'(level);
  end

`ifdef FMC_WR_FIFO_PEAK_EN
  logic [PW-1:0] peak_q;

  always_ff @(posedge clk) begin
    if (reset || flush)      peak_q <= '0;
    else if (level > peak_q) peak_q <= level;
  end

  assign peak = 16'(peak_q);
`endif

endmodule
